move_exec_arbiter: RTL
======================

Name: move_exec_arbiter

Overview:
- Shares one fixed-latency move_executor datapath among NUM_REQ requesters, e.g. search workers, UI/PGN replay and the legality checker.
- Accepts (board_t, move_t) jobs on per-requester valid/ready ports and issues at most one job per cycle, granted round-robin.
- Tracks in-flight jobs with a tag pipe, buffers results in a response FIFO and returns each result only to the requester that issued it.
- Applies credit-based flow control, because the executor has no backpressure.

Parameters:
- NUM_REQ, 4, number of requester ports; must be ≥2.
- EXEC_LATENCY, 1, cycles from the executor sampling valid_in to asserting valid_out; must be ≥1.
- RESP_DEPTH, 4, response FIFO entries; must be ≥EXEC_LATENCY+1.
- TAG_W, $clog2(NUM_REQ), requester tag width.

Ports:
- clk_in  in  1  system clock.
- rst_n_in  in  1  asynchronous active-low reset.
- req_valid_in  in  NUM_REQ  per-requester job valid.
- req_ready_out  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_board_in  in  NUM_REQ x board_t  board to apply the move to.
- req_move_in  in  NUM_REQ x move_t  move to execute.
- exec_valid_out  out  1  job issue to the executor.
- exec_board_out  out  board_t  board to the executor.
- exec_move_out  out  move_t  move to the executor.
- exec_valid_in  in  1  executor result valid.
- exec_board_in  in  board_t  resulting board.
- exec_captured_in  in  1  capture flag from the executor.
- resp_valid_out  out  NUM_REQ  one-hot response valid.
- resp_ready_in  in  NUM_REQ  per-requester response accept.
- resp_board_out  out  board_t  result board, shared bus.
- resp_captured_out  out  1  result capture flag.
- busy_out  out  1  any job in flight or buffered.
- error_out  out  1  sticky protocol error.

Behaviour:
- Reset (rst_n_in low, asynchronous): all outputs 0, rr_ptr=0, tag pipe cleared, FIFO empty, credit count=0, blank counter=EXEC_LATENCY. Any job in flight at reset is discarded.
- Grant: combinational. Pick the lowest index ≥rr_ptr with req_valid_in set, wrapping modulo NUM_REQ. Grant only if count<RESP_DEPTH; otherwise no grant.
- req_ready_out[g]=1 only for the granted index, and only while its valid is high. Ready may depend on valid.
- Transfer occurs when valid&ready. On transfer, rr_ptr←(g+1) mod NUM_REQ. With no transfer, rr_ptr holds.
- Issue stage is registered. A transfer at edge T drives exec_valid_out, exec_board_out and exec_move_out high/valid for exactly cycle T+1. exec_valid_out=0 in every other cycle. exec_* data holds its last value when not valid.
- Tag pipe: shift register of EXEC_LATENCY {valid, tag} entries, loaded from the issue register. Its output is aligned with exec_valid_in.
- On exec_valid_in=1 with pipe output valid: write {tag, exec_board_in, exec_captured_in} into the FIFO at that edge.
- Mismatch rule: if exec_valid_in differs from the pipe output valid, set error_out (sticky until reset) and drop the result. Exception: the first EXEC_LATENCY cycles after reset release are a blanking window, where stray exec_valid_in is ignored and not flagged.
- Response: when the FIFO is non-empty, resp_valid_out=one-hot(head.tag) and resp_board_out/resp_captured_out = head fields. Pop when resp_ready_in[head.tag]=1. Head-of-line order is preserved; other requesters' ready bits are ignored.
- End-to-end latency, no stall: accept at edge T, resp_valid_out from cycle T+2+EXEC_LATENCY. With EXEC_LATENCY=1 that is 3 cycles.
- Credits: count = issue reg + tag pipe + FIFO occupancy.
  - Issue only if count<RESP_DEPTH.
  - Same-cycle accept and pop leaves count unchanged.
  - Hence the FIFO can never overflow; a write to a full FIFO is an internal error and sets error_out.
- Throughput: one job per cycle sustained when responses are consumed immediately.
- busy_out = (count!=0).
- Board/move data is passed through unmodified; this block never inspects chess fields.

Decomposition:
- chess_pkg (shared): board_t, move_t, and a new resp_entry_t {tag, board_t board, captured}.
- Sub-module resp_fifo: synchronous FIFO of resp_entry_t, parameter DEPTH, async active-low reset, with push/pop/full/empty/count.
- Round-robin grant and tag pipe stay inline.

Test Plan:
- Single job: requester 2 sends a start-position board with move e2e4; accept at edge 0 → exec_valid_out in cycle 1. Executor returns ply=1 with the e2e4 pawn moved → resp_valid_out=4'b0100 in cycle 3, board matches, captured=0.
- Contention: all 4 valid continuously from reset, resp_ready_in all 1 → accept order 0,1,2,3,0, one per cycle. Responses arrive in the same order, each one-hot to the issuer.
- Backpressure: resp_ready_in=0, requester 0 streams jobs → exactly RESP_DEPTH=4 accepted, then req_ready_out=0. One pop → exactly one more accept. No loss or duplication.
- Simultaneous accept and pop at count=4: count stays 4 and no extra grant occurs. rr_ptr wrap from 3→0 is verified.
- Protocol error: inject exec_valid_in with an empty tag pipe at cycle 10 after reset → error_out=1 and stays 1, FIFO unchanged. The same injection in cycle 0 after reset (blanking) → no error.
- Reset mid-operation: assert rst_n_in while 3 jobs are in flight → all outputs 0 immediately (asynchronously), busy_out=0. No response is emitted for the old jobs after release.

Source files
------------

// File: rtl/move_exec_arbiter_pkg.sv
// Shared chess data types for the move executor arbiter.
// board_t/move_t pass through untouched; resp_entry_t is one buffered result.
package move_exec_arbiter_pkg;

  localparam int TAG_MAX_W = 8;

  typedef struct packed {
    logic [63:0][3:0] sq;
    logic             stm;
    logic [3:0]       castle;
    logic [5:0]       ep;
    logic [15:0]      ply;
  } board_t;

  typedef struct packed {
    logic [5:0] src;
    logic [5:0] dst;
    logic [2:0] promo;
  } move_t;

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    board_t               board;
    logic                 captured;
  } resp_entry_t;

endpackage

// File: rtl/move_exec_arbiter_resp_fifo.sv
// Response FIFO of resp_entry_t.
// Ports: clk_in, rst_n_in, push_in/data_in, pop_in, head_out, full/empty/count.
module resp_fifo
  import move_exec_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic          push_in,
  input  resp_entry_t   data_in,
  input  logic          pop_in,
  output resp_entry_t   head_out,
  output logic          full_out,
  output logic          empty_out,
  output logic [CW-1:0] count_out
);

  resp_entry_t   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] nxt(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_out  = (r_cnt == CW'(DEPTH));
  assign empty_out = (r_cnt == '0);
  assign count_out = r_cnt;
  assign head_out  = r_mem[r_rp];
  assign w_push    = push_in && !full_out;
  assign w_pop     = pop_in && !empty_out;

  always_ff @(posedge clk_in) begin
    if (w_push) r_mem[r_wp] <= data_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= nxt(r_wp);
      if (w_pop)  r_rp <= nxt(r_rp);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/move_exec_arbiter.sv
// Round-robin arbiter sharing one fixed-latency move executor among requesters.
// Ports: req_* job in, exec_* executor link, resp_* results out, busy/error status.
module move_exec_arbiter
  import move_exec_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int EXEC_LATENCY = 1,
  parameter int RESP_DEPTH   = 4,
  parameter int TAG_W        = $clog2(NUM_REQ)
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic [NUM_REQ-1:0]         req_valid_in,
  output logic [NUM_REQ-1:0]         req_ready_out,
  input  board_t [NUM_REQ-1:0]       req_board_in,
  input  move_t  [NUM_REQ-1:0]       req_move_in,
  output logic                       exec_valid_out,
  output board_t                     exec_board_out,
  output move_t                      exec_move_out,
  input  logic                       exec_valid_in,
  input  board_t                     exec_board_in,
  input  logic                       exec_captured_in,
  output logic [NUM_REQ-1:0]         resp_valid_out,
  input  logic [NUM_REQ-1:0]         resp_ready_in,
  output board_t                     resp_board_out,
  output logic                       resp_captured_out,
  output logic                       busy_out,
  output logic                       error_out
);

  localparam int FCW = $clog2(RESP_DEPTH + 1);
  localparam int CW  = $clog2(RESP_DEPTH + EXEC_LATENCY + 2) + 1;
  localparam int BW  = $clog2(EXEC_LATENCY + 1);
  localparam int LT  = EXEC_LATENCY - 1;

  logic [TAG_W-1:0]    r_rr;
  logic                r_iss_v;
  logic [TAG_W-1:0]    r_iss_tag;
  board_t              r_iss_board;
  move_t               r_iss_move;
  logic [LT:0]         r_pv;
  logic [TAG_W-1:0]    r_pt [EXEC_LATENCY];
  logic [BW-1:0]       r_blank;
  logic                r_err;

  logic                w_gnt_v;
  logic [TAG_W-1:0]    w_gnt;
  logic                w_ok;
  logic                w_xfer;
  logic [CW-1:0]       w_pcnt;
  logic [CW-1:0]       w_count;
  logic                w_blank;
  logic                w_mis;
  logic                w_hit;
  logic                w_ovf;
  resp_entry_t         w_wr;
  resp_entry_t         w_head;
  logic                w_full;
  logic                w_empty;
  logic [FCW-1:0]      w_fcnt;
  logic                w_tag_ok;
  logic [TAG_W-1:0]    w_htag;
  logic                w_pop;

  // Walk from the highest offset down so the lowest offset from r_rr wins.
  always_comb begin
    w_gnt_v = 1'b0;
    w_gnt   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_in[TAG_W'((int'(r_rr) + i) % NUM_REQ)]) begin
        w_gnt_v = 1'b1;
        w_gnt   = TAG_W'((int'(r_rr) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    w_pcnt = '0;
    for (int i = 0; i < EXEC_LATENCY; i++) begin
      w_pcnt = w_pcnt + CW'(r_pv[i]);
    end
  end

  assign w_count = CW'(r_iss_v) + w_pcnt + CW'(w_fcnt);
  // Gating with rst_n_in keeps ready low while reset is held.
  assign w_ok    = rst_n_in && (w_count < CW'(RESP_DEPTH));

  always_comb begin
    req_ready_out = '0;
    if (w_gnt_v && w_ok) req_ready_out[w_gnt] = 1'b1;
  end

  assign w_xfer  = |req_ready_out;
  assign w_blank = (r_blank != '0);
  assign w_mis   = (exec_valid_in != r_pv[LT]) && !w_blank;
  assign w_hit   = exec_valid_in && r_pv[LT] && !w_blank;
  assign w_ovf   = w_hit && w_full;

  assign w_wr.tag      = TAG_MAX_W'(r_pt[LT]);
  assign w_wr.board    = exec_board_in;
  assign w_wr.captured = exec_captured_in;

  resp_fifo #(
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push_in   (w_hit),
    .data_in   (w_wr),
    .pop_in    (w_pop),
    .head_out  (w_head),
    .full_out  (w_full),
    .empty_out (w_empty),
    .count_out (w_fcnt)
  );

  assign w_tag_ok = !w_empty && (int'(w_head.tag) < NUM_REQ);
  assign w_htag   = w_head.tag[TAG_W-1:0];
  assign w_pop    = w_tag_ok && resp_ready_in[w_htag];

  always_comb begin
    resp_valid_out = '0;
    if (w_tag_ok) resp_valid_out[w_htag] = 1'b1;
  end

  assign resp_board_out    = w_empty ? '0 : w_head.board;
  assign resp_captured_out = !w_empty && w_head.captured;
  assign exec_valid_out    = r_iss_v;
  assign exec_board_out    = r_iss_board;
  assign exec_move_out     = r_iss_move;
  assign busy_out          = (w_count != '0);
  assign error_out         = r_err;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rr        <= '0;
      r_iss_v     <= 1'b0;
      r_iss_tag   <= '0;
      r_iss_board <= '0;
      r_iss_move  <= '0;
      r_pv        <= '0;
      for (int i = 0; i < EXEC_LATENCY; i++) r_pt[i] <= '0;
      r_blank     <= BW'(EXEC_LATENCY);
      r_err       <= 1'b0;
    end else begin
      r_iss_v <= w_xfer;
      if (w_xfer) begin
        r_iss_tag   <= w_gnt;
        r_iss_board <= req_board_in[w_gnt];
        r_iss_move  <= req_move_in[w_gnt];
        r_rr        <= TAG_W'((int'(w_gnt) + 1) % NUM_REQ);
      end
      r_pv[0] <= r_iss_v;
      r_pt[0] <= r_iss_tag;
      for (int i = 1; i < EXEC_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pt[i] <= r_pt[i-1];
      end
      if (w_blank) r_blank <= r_blank - BW'(1);
      if (w_mis || w_ovf) r_err <= 1'b1;
    end
  end

endmodule
